axi_bridge_regslice: RTL

AXI_BRIDGE_REGSLICE -- requirements
Module: axi_bridge_regslice

---
 rtl/axi_bridge_regslice.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/axi_bridge_regslice.sv
// axi_bridge_regslice: five independent AXI channel register slices (passthrough, 2-entry skid or 1-entry)
module axi_bridge_regslice_slice #(
    parameter int W = 8,
    parameter int MODE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    if (MODE == 0) begin : g_wire
        assign out_data = in_data;
        assign out_valid = in_valid;
        assign in_ready = out_ready;
        assign busy = 1'b0;
    end else begin : g_reg
        state_t state, state_n;
        logic ready_q;
        logic [W-1:0] out_q, skid_q;
        logic in_hs, out_hs;
        assign in_hs = in_valid && ready_q;
        assign out_hs = out_ready && state != EMPTY;
        // occupancy transitions; the 1-entry slice never reaches TWO because its ready is low in ONE
        always_comb begin
            state_n = state == EMPTY ? (in_hs ? ONE : EMPTY) :
                      state == ONE   ? (in_hs && !out_hs ? TWO : !in_hs && out_hs ? EMPTY : ONE) :
                                       (out_hs ? ONE : TWO);
        end
        // state, registered source ready and payload registers
        always_ff @(posedge clk) begin
            if (rst) begin
                state <= EMPTY;
                ready_q <= 1'b0;
                out_q <= '0;
                skid_q <= '0;
            end else begin
                state <= state_n;
                ready_q <= MODE == 2 ? state_n == EMPTY : state_n != TWO;
                if (in_hs && (state == EMPTY || out_hs))
                    out_q <= in_data;
                else if (state == TWO && out_hs)
                    out_q <= skid_q;
                if (in_hs && state == ONE && !out_hs)
                    skid_q <= in_data;
            end
        end
        assign in_ready = ready_q;
        assign out_valid = state != EMPTY;
        assign out_data = out_q;
        assign busy = state != EMPTY;
    end
endmodule

module axi_bridge_regslice #(
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AW_MODE = 1,
    parameter int C_W_MODE = 1,
    parameter int C_B_MODE = 1,
    parameter int C_AR_MODE = 1,
    parameter int C_R_MODE = 1
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                    s_axi_awprot,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [C_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                    s_axi_arprot,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [C_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                    m_axi_awprot,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [C_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                    m_axi_arprot,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [C_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    output logic                          idle
);
    localparam int AW = C_AXI_ADDR_WIDTH + 3;
    localparam int WW = C_AXI_DATA_WIDTH + C_AXI_DATA_WIDTH / 8;
    localparam int RW = C_AXI_DATA_WIDTH + 2;
    logic [4:0] busy;
    logic [AW-1:0] aw_out, ar_out;
    logic [WW-1:0] w_out;
    logic [RW-1:0] r_out;
    assign {m_axi_awaddr, m_axi_awprot} = aw_out;
    assign {m_axi_wdata, m_axi_wstrb} = w_out;
    assign {m_axi_araddr, m_axi_arprot} = ar_out;
    assign {s_axi_rdata, s_axi_rresp} = r_out;
    assign idle = ~|busy;
    axi_bridge_regslice_slice #(.W(AW), .MODE(C_AW_MODE)) u_aw (
        .clk(aclk), .rst(areset), .in_data({s_axi_awaddr, s_axi_awprot}), .in_valid(s_axi_awvalid),
        .in_ready(s_axi_awready), .out_data(aw_out), .out_valid(m_axi_awvalid),
        .out_ready(m_axi_awready), .busy(busy[0]));
    axi_bridge_regslice_slice #(.W(WW), .MODE(C_W_MODE)) u_w (
        .clk(aclk), .rst(areset), .in_data({s_axi_wdata, s_axi_wstrb}), .in_valid(s_axi_wvalid),
        .in_ready(s_axi_wready), .out_data(w_out), .out_valid(m_axi_wvalid),
        .out_ready(m_axi_wready), .busy(busy[1]));
    axi_bridge_regslice_slice #(.W(2), .MODE(C_B_MODE)) u_b (
        .clk(aclk), .rst(areset), .in_data(m_axi_bresp), .in_valid(m_axi_bvalid),
        .in_ready(m_axi_bready), .out_data(s_axi_bresp), .out_valid(s_axi_bvalid),
        .out_ready(s_axi_bready), .busy(busy[2]));
    axi_bridge_regslice_slice #(.W(AW), .MODE(C_AR_MODE)) u_ar (
        .clk(aclk), .rst(areset), .in_data({s_axi_araddr, s_axi_arprot}), .in_valid(s_axi_arvalid),
        .in_ready(s_axi_arready), .out_data(ar_out), .out_valid(m_axi_arvalid),
        .out_ready(m_axi_arready), .busy(busy[3]));
    axi_bridge_regslice_slice #(.W(RW), .MODE(C_R_MODE)) u_r (
        .clk(aclk), .rst(areset), .in_data({m_axi_rdata, m_axi_rresp}), .in_valid(m_axi_rvalid),
        .in_ready(m_axi_rready), .out_data(r_out), .out_valid(s_axi_rvalid),
        .out_ready(s_axi_rready), .busy(busy[4]));
endmodule
